apb4_cmd_master: RTL

APB4_CMD_MASTER -- requirements
Module: apb4_cmd_master
Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 32, APB address width; DATA_WIDTH, 32, APB data width (8/16/32); TIMEOUT_CYCLES, 16, max ACCESS cycles waiting for pready (>=1).
REQ-002 The block SHALL use one clock, pclk, and an asynchronous active-low reset, presetn.
REQ-003 Ports SHALL be:
- pclk  in  1  APB clock, all logic on rising edge
- presetn  in  1  async active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  write byte strobes
- cmd_prot  in  3  protection attributes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes/timeouts)
- rsp_err  out  1  pslverr or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- psel, penable, pwrite  out  1 each  APB control
- paddr  out  ADDR_WIDTH  APB address
- pwdata  out  DATA_WIDTH  APB write data
- pstrb  out  DATA_WIDTH/8  APB strobes
- pprot  out  3  APB protection
- prdata  in  DATA_WIDTH  slave read data
- pready, pslverr  in  1 each  slave ready/error
Function
REQ-004 FSM states SHALL be IDLE, SETUP, ACCESS, RESP; all APB and rsp outputs registered.
REQ-005 cmd_ready SHALL be high only in IDLE; cmd_valid&&cmd_ready captures cmd_* into holding registers and moves to SETUP.
REQ-006 SETUP (exactly 1 cycle): psel=1, penable=0, paddr/pwrite/pwdata/pprot from captured command; next state ACCESS.
REQ-007 ACCESS: psel=1, penable=1, all address/control/data stable from SETUP; stays while pready=0.
REQ-008 pstrb SHALL equal captured cmd_strb for writes and all-zero for reads; pwdata SHALL be 0 for reads.
REQ-009 ACCESS with pready=1: capture prdata (reads only, else 0) to rsp_rdata, pslverr to rsp_err, rsp_timeout=0; deassert psel/penable next cycle; go RESP.
REQ-010 Timeout counter SHALL clear on SETUP entry, increment each ACCESS cycle with pready=0; when count reaches TIMEOUT_CYCLES, next cycle psel=penable=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0, go RESP.
REQ-011 pready=1 in the same cycle the counter reaches TIMEOUT_CYCLES SHALL complete normally (pready wins).
REQ-012 RESP: rsp_valid=1, rsp_* held stable until rsp_valid&&rsp_ready, then IDLE; no new command accepted before IDLE (one outstanding transfer).
REQ-013 Minimum latency: handshake at edge N -> psel at N+1, penable at N+2, rsp_valid at N+3 with zero wait states; back-to-back commands incur one IDLE cycle (psel low >=1 cycle).
REQ-014 pready/pslverr/prdata SHALL be ignored outside ACCESS.
Reset
REQ-015 presetn low SHALL immediately force IDLE, psel=penable=pwrite=0, paddr/pwdata/pstrb/pprot=0, rsp_valid=rsp_err=rsp_timeout=0, rsp_rdata=0, counter=0, cmd_ready=0 during reset and 1 from first edge after release; reset mid-transfer aborts with no response.
Verification
REQ-016 Write 0x0000_0010 <= 0xDEAD_BEEF, strb 0xF, pready=1 -> SETUP/ACCESS one cycle each, pstrb=0xF, rsp_valid at N+3, rsp_err=0.
REQ-017 Read 0x0000_0004, pready low 3 ACCESS cycles, prdata=0x1234_5678 -> paddr stable 5 cycles, rsp_rdata=0x1234_5678, pstrb=0.
REQ-018 Write with pslverr=1 on ready -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
REQ-019 pready held 0, TIMEOUT_CYCLES=16 -> psel drops after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1; pready at cycle 16 -> normal completion.
REQ-020 rsp_ready held 0 for 5 cycles with cmd_valid high -> cmd_ready=0, rsp stable; then back-to-back commands show one IDLE gap.
REQ-021 presetn asserted during ACCESS -> all outputs zero asynchronously, no rsp_valid after release.

---
 rtl/apb4_cmd_master_if.sv | 46 ++++
 rtl/apb4_cmd_master.sv | 125 ++++++++++++
 2 files changed

// File: rtl/apb4_cmd_master_if.sv
// apb4_cmd_master_if: command/response handshakes and APB4 bus of the command master
interface apb4_cmd_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [DATA_WIDTH-1:0]   cmd_wdata;
    logic [DATA_WIDTH/8-1:0] cmd_strb;
    logic [2:0]              cmd_prot;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;
    logic                    rsp_timeout;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [2:0]              pprot;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb4_cmd_master.sv
// apb4_cmd_master: turns single commands into APB4 transfers with a wait-state timeout
module apb4_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic               pclk,
    input logic               presetn,
    apb4_cmd_master_if.master bus
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [SW-1:0]         pstrb_q, pstrb_d;
    logic [2:0]            pprot_q, pprot_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  timeout_hit;

    // the last wait state that still sees pready low ends the transfer
    assign timeout_hit = state_q == ACCESS && !bus.pready && cnt_q == CW'(TIMEOUT_CYCLES - 1);

    // state and all registered outputs, cleared asynchronously by reset
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // next state: one outstanding transfer, pready wins over the timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.cmd_valid && cmd_ready_q) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (bus.pready || timeout_hit) state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // outputs for the coming state; command captured on accept, response on completion
    always_comb begin
        cmd_ready_d   = state_d == IDLE;
        psel_d        = state_d == SETUP || state_d == ACCESS;
        penable_d     = state_d == ACCESS;
        rsp_valid_d   = state_d == RESP;
        cnt_d         = cnt_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        if (state_q == IDLE && state_d == SETUP) begin
            cnt_d    = '0;
            pwrite_d = bus.cmd_write;
            paddr_d  = bus.cmd_addr;
            pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
            pstrb_d  = bus.cmd_write ? bus.cmd_strb : '0;
            pprot_d  = bus.cmd_prot;
        end
        if (state_q == ACCESS && !bus.pready) cnt_d = cnt_q + CW'(1);
        if (state_q == ACCESS && state_d == RESP) begin
            rsp_rdata_d   = bus.pready && !pwrite_q ? bus.prdata : '0;
            rsp_err_d     = bus.pready ? bus.pslverr : 1'b1;
            rsp_timeout_d = !bus.pready;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.pstrb       = pstrb_q;
    assign bus.pprot       = pprot_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
endmodule
